// File: rtl/seq_scan_ctrl_if.sv
// Detector-side bundle of seq_scan_ctrl: clear, serial bit stream, hit pulse.
// master = sequencer, slave = detector core.
interface seq_scan_ctrl_if;
  logic det_clr;
  logic det_valid;
  logic det_bit;
  logic det_hit;

  modport master (
    output det_clr,
    output det_valid,
    output det_bit,
    input  det_hit
  );

  modport slave (
    input  det_clr,
    input  det_valid,
    input  det_bit,
    output det_hit
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Scan sequencer: serializes a switch pattern into the detector, counts hits.
// SEQ_SCAN_CTRL_CIRCULAR_EN: rotate pattern, shift 2*WIDTH-1 bits.
module seq_scan_ctrl #(
  parameter int WIDTH     = 10,
  parameter int CNT_W     = 4,
  parameter int DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    pattern,
  seq_scan_ctrl_if.master     det,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [CNT_W-1:0]    match_count
);

`ifdef SEQ_SCAN_CTRL_CIRCULAR_EN
  localparam int SHIFT_LEN = 2*WIDTH - 1;
`else
  localparam int SHIFT_LEN = WIDTH;
`endif

  localparam int CW = $clog2(SHIFT_LEN + DRAIN_CYC + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic             en_d;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bcnt;
  logic             start;
  logic             load;
  logic             shift;
  logic             abort;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             hit_ok;

  assign start = en & ~en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    abort     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    hit_ok    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!en) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          load      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        hit_ok = 1'b1;
        if (!en) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          shift = 1'b1;
          if (bcnt == SHIFT_LAST) begin
            cnt_clr   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        hit_ok = 1'b1;
        if (!en) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (bcnt == DRAIN_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (!en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One counter serves both the SHIFT bit index and the DRAIN wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d    <= 1'b0;
      shreg   <= '0;
      bcnt    <= '0;
      aborted <= 1'b0;
    end else begin
      en_d    <= en;
      aborted <= abort;
      if (load) begin
        shreg <= pattern;
      end else if (shift) begin
`ifdef SEQ_SCAN_CTRL_CIRCULAR_EN
        shreg <= {shreg[WIDTH-2:0], shreg[WIDTH-1]};
`else
        shreg <= {shreg[WIDTH-2:0], 1'b0};
`endif
      end
      if (cnt_clr) begin
        bcnt <= '0;
      end else if (cnt_inc) begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (load) begin
      match_count <= '0;
    end else if (hit_ok && det.det_hit && match_count != CNT_MAX) begin
      match_count <= match_count + 1'b1;
    end
  end

  assign det.det_clr   = (state == LOAD);
  assign det.det_valid = (state == SHIFT);
  assign det.det_bit   = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign busy          = (state == LOAD) || (state == SHIFT) || (state == DRAIN);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: "101" detector model, vector table, random scans.
// Expectations follow SEQ_SCAN_CTRL_CIRCULAR_EN when defined.
module tb_seq_scan_ctrl;

  localparam int W = 10;
`ifdef SEQ_SCAN_CTRL_CIRCULAR_EN
  localparam int SLEN    = 2*W - 1;
  localparam int SMALL_W = 3;
`else
  localparam int SLEN    = W;
  localparam int SMALL_W = 2;
`endif
  localparam int LAT       = 1 + SLEN + 2;
  localparam int MAIN_MAX  = 15;
  localparam int SMALL_MAX = (1 << SMALL_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [W-1:0] pattern;
  logic inj;

  logic busy, done, aborted;
  logic [3:0] match_count;
  logic s_busy, s_done, s_aborted;
  logic [SMALL_W-1:0] s_match_count;

  seq_scan_ctrl_if di ();
  seq_scan_ctrl_if ds ();

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(4), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .det(di),
    .busy(busy), .done(done), .aborted(aborted),
    .match_count(match_count)
  );

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(SMALL_W), .DRAIN_CYC(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .det(ds),
    .busy(s_busy), .done(s_done), .aborted(s_aborted),
    .match_count(s_match_count)
  );

  // Detector model: overlapping "101", hit one cycle after the third bit.
  logic [1:0] hist_m, hist_s;
  logic hit_m, hit_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_m <= '0;
      hit_m  <= 1'b0;
    end else begin
      hit_m <= di.det_valid && ({hist_m, di.det_bit} == 3'b101);
      if (di.det_clr) hist_m <= '0;
      else if (di.det_valid) hist_m <= {hist_m[0], di.det_bit};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_s <= '0;
      hit_s  <= 1'b0;
    end else begin
      hit_s <= ds.det_valid && ({hist_s, ds.det_bit} == 3'b101);
      if (ds.det_clr) hist_s <= '0;
      else if (ds.det_valid) hist_s <= {hist_s[0], ds.det_bit};
    end
  end

  assign di.det_hit = hit_m | inj;
  assign ds.det_hit = hit_s | inj;

  int total = 0;
  int bad   = 0;
  logic stream[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit stream the detector should see: pattern MSB first, plus wrap bits.
  function automatic void build_stream(input logic [W-1:0] p);
    stream.delete();
    for (int i = W-1; i >= 0; i--) stream.push_back(p[i]);
`ifdef SEQ_SCAN_CTRL_CIRCULAR_EN
    for (int i = W-1; i >= 1; i--) stream.push_back(p[i]);
`endif
  endfunction

  function automatic int ref_hits(input logic [W-1:0] p);
    int n = 0;
    build_stream(p);
    for (int i = 0; i + 2 < stream.size(); i++)
      if (stream[i] && !stream[i+1] && stream[i+2]) n++;
    return n;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic finish_scan(input logic [W-1:0] p, input int ec,
                             input int es, input string nm);
    int n;
    int be;
    logic got[$];
    build_stream(p);
    check({nm, " clr"}, int'(di.det_clr), 1);
    check({nm, " busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      pattern = W'($urandom);
      if (di.det_valid) got.push_back(di.det_bit);
    end
    check({nm, " latency"}, n, LAT);
    check({nm, " nbits"}, got.size(), stream.size());
    be = 0;
    for (int i = 0; i < stream.size(); i++)
      if (i >= got.size() || got[i] !== stream[i]) be++;
    check({nm, " bits"}, be, 0);
    check({nm, " count"}, int'(match_count), ec);
    check({nm, " count_small"}, int'(s_match_count), es);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    check({nm, " done_hit_ignored"}, int'(match_count), ec);
    check({nm, " done_hold"}, int'(done), 1);
  endtask

  task automatic run_scan(input logic [W-1:0] p, input int ec,
                          input int es, input string nm);
    en = 1'b0;
    repeat (5) tick();
    check({nm, " idle_done"}, int'(done), 0);
    check({nm, " idle_abort"}, int'(aborted), 0);
    pattern = p;
    en = 1'b1;
    tick();
    finish_scan(p, ec, es, nm);
  endtask

  typedef struct {
    logic [W-1:0] pat;
    int           cnt;
    int           cnt_small;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [W-1:0] rp;
    int r;
`ifdef SEQ_SCAN_CTRL_CIRCULAR_EN
    vt[0] = '{10'b1010101010, 9, 7};
    vt[1] = '{10'b1100110011, 0, 0};
    vt[2] = '{10'b0100000001, 1, 1};
    vt[3] = '{10'b1111111111, 0, 0};
    vt[4] = '{10'b0000000000, 0, 0};
    vt[5] = '{10'b1011011011, 6, 6};
`else
    vt[0] = '{10'b1010101010, 4, 3};
    vt[1] = '{10'b1100110011, 0, 0};
    vt[2] = '{10'b0100000001, 0, 0};
    vt[3] = '{10'b1111111111, 0, 0};
    vt[4] = '{10'b0000000000, 0, 0};
    vt[5] = '{10'b1011011011, 3, 3};
`endif
    inj = 1'b0;
    rst = 1'b1;
    en = 1'b1;
    pattern = 10'b1010101010;
    #20;
    check("rst clr", int'(di.det_clr), 0);
    check("rst valid", int'(di.det_valid), 0);
    check("rst bit", int'(di.det_bit), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst aborted", int'(aborted), 0);
    check("rst count", int'(match_count), 0);

    // Released with en already high: first edge starts the scan.
    rst = 1'b0;
    tick();
    finish_scan(10'b1010101010, vt[0].cnt, vt[0].cnt_small, "first");

    for (int i = 0; i < 6; i++)
      run_scan(vt[i].pat, vt[i].cnt, vt[i].cnt_small, $sformatf("vec%0d", i));

    // Abort after four SHIFT cycles; one hit already seen.
    en = 1'b0;
    repeat (3) tick();
    pattern = 10'b1010101010;
    en = 1'b1;
    tick();
    repeat (4) tick();
    en = 1'b0;
    tick();
    check("abort pulse", int'(aborted), 1);
    check("abort valid", int'(di.det_valid), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort count", int'(match_count), 1);
    tick();
    check("abort pulse_end", int'(aborted), 0);
    check("abort count_hold", int'(match_count), 1);

    // Async reset mid-SHIFT with en held high.
    pattern = 10'b1011011011;
    en = 1'b1;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("mrst valid", int'(di.det_valid), 0);
    check("mrst bit", int'(di.det_bit), 0);
    check("mrst busy", int'(busy), 0);
    check("mrst count", int'(match_count), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    finish_scan(10'b1011011011, vt[5].cnt, vt[5].cnt_small, "after_rst");

    for (int k = 0; k < 20; k++) begin
      rp = W'($urandom);
      r = ref_hits(rp);
      run_scan(rp, sat(r, MAIN_MAX), sat(r, SMALL_MAX),
               $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Sequencer for the serial sequence-detector datapath.
- On a rising edge of the enable switch, captures the 10-bit switch pattern and shifts it into the detector one bit per clock, MSB first.
- Counts detector hits into a saturating match count, then signals done.
- Sits between the board switches and the detector core; its match_count drives the 4-bit display output.

Parameters:
- WIDTH, 10, number of pattern bits serialized per scan
- CNT_W, 4, width of match_count; saturates at 2^CNT_W-1
- DRAIN_CYC, 2, cycles after the last bit during which late detector hits are still counted (must be >= detector hit latency)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable (switches[WIDTH]); rising edge starts a scan, low aborts or releases
- pattern  input  WIDTH  parallel pattern (switches[WIDTH-1:0]); sampled only in LOAD
- det_clr  output  1  one-cycle clear pulse to detector, asserted in LOAD
- det_valid  output  1  high while det_bit carries a valid pattern bit
- det_bit  output  1  current serial bit, MSB of shift register
- det_hit  input  1  single-cycle match pulse from detector
- busy  output  1  high in LOAD, SHIFT, DRAIN
- done  output  1  high in DONE
- aborted  output  1  one-cycle pulse when en falls during busy
- match_count  output  CNT_W  hits counted in the current or last scan

Behaviour:
- Reset: state IDLE; all outputs 0; shift register, bit counter and match_count 0; en_d (registered en) 0. If en is high when rst deasserts, the scan starts on the first clock edge.
- Edge detect: start = en & ~en_d, evaluated every clock.
- IDLE:
  - on start -> LOAD.
  - match_count holds its last value.
- LOAD, 1 cycle:
  - shift reg <= pattern; bit counter <= 0; match_count <= 0; det_clr = 1.
  - -> SHIFT.
- SHIFT, exactly WIDTH cycles:
  - det_valid = 1, det_bit = shreg[WIDTH-1]; shreg shifts left each cycle, zero fill.
  - After bit WIDTH-1 -> DRAIN.
- DRAIN, exactly DRAIN_CYC cycles:
  - det_valid = 0, det_bit = 0.
  - -> DONE.
- DONE:
  - done = 1, busy = 0; match_count frozen.
  - en low -> IDLE. A new scan needs en to go low and then high again.
- Hit counting:
  - counted only in SHIFT and DRAIN; match_count increments by 1 per det_hit cycle.
  - saturates at 2^CNT_W-1; no wrap.
  - det_hit in IDLE, LOAD or DONE is ignored.
- Abort: en low in LOAD, SHIFT or DRAIN ->
  - next state IDLE; aborted pulses 1 cycle; det_valid drops the same edge.
  - match_count retains its partial value; done not asserted.
- Latency: from the edge sampling start to done = 1 + WIDTH + DRAIN_CYC cycles (13 at defaults).
- Pattern changes after LOAD have no effect on the current scan.
- Async rst mid-scan: immediate return to the reset values above.

Optional Feature:
- Macro: SEQ_SCAN_CTRL_CIRCULAR_EN.
- Defined: shift register rotates (MSB re-enters at LSB) and SHIFT lasts 2*WIDTH-1 cycles, so matches spanning the pattern wrap are counted. Latency becomes 1 + (2*WIDTH-1) + DRAIN_CYC = 22 cycles at defaults.
- Undefined: zero-fill shift, WIDTH cycles, as above.

Test Plan:
- Bench detector model for "101", overlapping, det_hit 1 cycle after the third bit.
  - rst high 20 ns, release with en=1, pattern=1010101010 -> det_clr pulse, then 10 det_valid cycles with bits 1,0,1,0,1,0,1,0,1,0; done at cycle 13; match_count=4.
- en low 5 cycles, then en=1 with pattern=1100110011 -> match_count cleared in LOAD, done, match_count=0.
- Pattern=0100000001 -> match_count=0 without the macro; =1 with SEQ_SCAN_CTRL_CIRCULAR_EN (done at cycle 22).
- CNT_W=3, macro defined, pattern=1010101010 -> 9 hits saturate, match_count=7.
- Start a scan, drop en after 4 SHIFT cycles -> aborted 1-cycle pulse, det_valid low next edge, done stays 0, match_count=1 retained.
- Assert rst mid-SHIFT with en held high -> all outputs 0 immediately; after release, a fresh scan starts and completes with the correct count.
